instr_prefetch: RTL

Instruction prefetch stage for the 16-bit programmable processor. It sits between the 32-word instruction ROM and the control unit. It keeps a 2-entry buffer of prefetched instructions and loads the instruction register (`IR_Out`) and its program-counter tag (`PC_Out`) when the controller requests a fetch. It also redirects the fetch stream on jumps.

---
 rtl/instr_prefetch_if.sv | 49 ++++
 rtl/instr_prefetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_if
//
// Purpose : Bundles the instruction prefetch stage's bus signals. The group
//           covers the ROM read port and the controller handshake.
//
// Modports:
//   master - the prefetch stage. It drives ROM_Rd/ROM_Addr and the
//            IR_Out/PC_Out/Avail results, and it receives ROM_Data and the
//            controller requests.
//   slave  - the environment: the ROM and the control unit.
//
// Signals:
//   Fetch    controller request to load the next instruction into IR
//   Jump     redirect the fetch stream to JumpAddr
//   JumpAddr jump target
//   Stall    inhibit new ROM reads
//   ROM_Rd   ROM read strobe
//   ROM_Addr ROM read address
//   ROM_Data ROM read data, valid the cycle after the sampling edge
//   IR_Out   instruction register
//   PC_Out   address of the instruction held in IR_Out
//   Avail    buffer non-empty, so a Fetch will be honoured
// -----------------------------------------------------------------------------
interface instr_prefetch_if #(
  parameter int AW = 5,
  parameter int IW = 16
);
  logic          Fetch;
  logic          Jump;
  logic [AW-1:0] JumpAddr;
  logic          Stall;
  logic          ROM_Rd;
  logic [AW-1:0] ROM_Addr;
  logic [IW-1:0] ROM_Data;
  logic [IW-1:0] IR_Out;
  logic [AW-1:0] PC_Out;
  logic          Avail;

  modport master (
    input  Fetch, Jump, JumpAddr, Stall, ROM_Data,
    output ROM_Rd, ROM_Addr, IR_Out, PC_Out, Avail
  );

  modport slave (
    output Fetch, Jump, JumpAddr, Stall, ROM_Data,
    input  ROM_Rd, ROM_Addr, IR_Out, PC_Out, Avail
  );
endinterface

// File: rtl/instr_prefetch.sv
// -----------------------------------------------------------------------------
// instr_prefetch
//
// Purpose : Instruction prefetch stage that sits between the instruction ROM
//           and the control unit.
//           - It reads ahead into a 2-entry buffer of {addr, instr} pairs.
//           - It loads IR_Out/PC_Out from the buffer head when Fetch is
//             requested.
//           - It redirects the stream on Jump. Jump flushes the buffer and
//             discards the read that is in flight.
//
// Ports:
//   Clk    system clock; every state change happens on the rising edge
//   Reset  synchronous, active-high
//   bus    instr_prefetch_if.master, which carries the ROM port
//          (ROM_Rd, ROM_Addr, ROM_Data) and the controller handshake
//          (Fetch, Jump, JumpAddr, Stall, IR_Out, PC_Out, Avail)
//
// ROM_Rd is combinational. ROM_Addr is the fetch PC register. Every other
// output is a register.
// -----------------------------------------------------------------------------
module instr_prefetch #(
  parameter int AW = 5,
  parameter int IW = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  instr_prefetch_if.master    bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0] r_fetch_pc;    // next address to read from ROM
  logic [AW-1:0] r_tag;         // address of the read currently in flight
  logic          r_in_flight;   // a ROM read was issued on the last edge
  logic          r_squash;      // discard the return that follows a jump
  logic [1:0]    r_count;       // buffer occupancy, 0..2

  logic [AW-1:0] r_q_addr  [2]; // slot 0 is always the head
  logic [IW-1:0] r_q_instr [2];

  logic [IW-1:0] r_ir;
  logic [AW-1:0] r_pc;
  logic          r_avail;

  // ---------------------------------------------------------------------------
  // Per-cycle decisions
  // ---------------------------------------------------------------------------
  logic       w_rom_rd;
  logic       w_push;
  logic       w_pop;
  logic       w_wr_slot;
  logic [1:0] w_occupancy;
  logic [1:0] w_count_nxt;

  // The occupancy counts the entry that is still in flight. Credit from a pop
  // in this cycle is deliberately ignored, so issue looks only at the state
  // before the edge. This is what keeps the buffer from overflowing.
  assign w_occupancy = r_count + {1'b0, r_in_flight};
  assign w_rom_rd    = !Reset && !bus.Stall && !bus.Jump && (w_occupancy < 2'd2);

  // Jump has priority over both a returning read and a fetch.
  assign w_push = r_in_flight && !r_squash && !bus.Jump;
  assign w_pop  = bus.Fetch && (r_count != 2'd0) && !bus.Jump;

  // Choose the destination slot for the returning instruction.
  // - On a pop the entries shift down first, so the new entry lands one
  //   slot lower.
  // - Push without pop never happens at count 2, because of the issue rule.
  assign w_wr_slot = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);

  // NOTE: every variable written in an always_comb gets a default first, so a
  // path that misses an assignment cannot infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.Jump) begin
      w_count_nxt = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample the values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fetch_pc  <= '0;
      r_tag       <= '0;
      r_in_flight <= 1'b0;
      r_squash    <= 1'b0;
      r_count     <= 2'd0;
      r_ir        <= '0;
      r_pc        <= '0;
      r_avail     <= 1'b0;
    end else begin
      r_in_flight <= w_rom_rd;
      r_squash    <= bus.Jump && r_in_flight;
      r_count     <= w_count_nxt;
      // Avail is a register, so it never depends combinationally on the
      // inputs of this cycle.
      r_avail     <= (w_count_nxt != 2'd0);

      if (w_rom_rd) begin
        r_tag <= r_fetch_pc;
      end

      // The PC wraps naturally modulo 2^AW.
      if (bus.Jump) begin
        r_fetch_pc <= bus.JumpAddr;
      end else if (w_rom_rd) begin
        r_fetch_pc <= r_fetch_pc + AW'(1);
      end

      if (w_pop) begin
        r_ir <= r_q_instr[0];
        r_pc <= r_q_addr[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. r_count alone decides which slots
  // are valid, so stale contents are never observed.
  //
  // If a pop shifts the entries and a push writes the same slot on the same
  // edge, the push wins. It is the later assignment.
  always_ff @(posedge Clk) begin
    if (w_pop) begin
      r_q_addr[0]  <= r_q_addr[1];
      r_q_instr[0] <= r_q_instr[1];
    end
    if (w_push) begin
      r_q_addr[w_wr_slot]  <= r_tag;
      r_q_instr[w_wr_slot] <= bus.ROM_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ROM_Rd   = w_rom_rd;
  assign bus.ROM_Addr = r_fetch_pc;
  assign bus.IR_Out   = r_ir;
  assign bus.PC_Out   = r_pc;
  assign bus.Avail    = r_avail;

endmodule
